ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Round-robin arbiter and command sequencer that shares the single-port command RAM (10-bit din with din[9:8] opcode, rx_valid, dout, tx_valid) among NUM_REQ requesters, e.g. the SPI slave path plus a debug/DMA port.
- Each requester issues whole write or read transactions on a valid/ready port.
- The block expands each transaction into the RAM's two-command sequence and returns completion/read data on a per-requester response strobe.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_SIZE, 8, RAM address width; the data width is fixed at 8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester transaction request; held until accepted
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses; requester i uses slice i
req_wdata  in  NUM_REQ*8  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  8  last read data
ram_din  out  10  command to RAM: {opcode, payload}
ram_rx_valid  out  1  command strobe to RAM
ram_dout  in  8  RAM read data
ram_tx_valid  in  1  RAM read-data valid (sticky in the RAM until its next command)
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE, RR pointer 0. All outputs 0: req_ready, rsp_valid, rsp_rdata, ram_din, ram_rx_valid, busy. Captured transaction registers are cleared.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is produced. RAM contents already written stay.
- Opcodes: 00 write address; 01 write data; 10 read address; 11 read data (payload 8'h00).
- State machine (all outputs registered or decoded from state):
  - IDLE: if any req_valid, grant the first asserted requester searching from the RR pointer upward with wrap. Pulse req_ready[g] this cycle, latch g/we/addr/wdata, go to ADDR. Otherwise stay.
  - ADDR: ram_rx_valid=1, ram_din={we?00:10, addr}. Go to DATA.
  - DATA: ram_rx_valid=1, ram_din = we ? {01,wdata} : {11,8'h00}. Write goes to RESP; read goes to WAIT_RD.
  - WAIT_RD: ram_rx_valid=0. If ram_tx_valid, capture ram_dout into rsp_rdata and go to RESP; otherwise stay. ram_tx_valid is ignored in every other state because it is sticky.
  - RESP: rsp_valid[g]=1 for exactly one cycle. RR pointer becomes (g+1) mod NUM_REQ. Go to IDLE.
- Latency from the accept cycle (cycle 0): write rsp_valid at cycle 3; read rsp_valid at cycle 4. One transaction is in flight at a time, and req_ready is only ever asserted in IDLE.
- rsp_rdata changes only on read capture; writes leave it unchanged.
- ram_rx_valid is 0 in IDLE, WAIT_RD and RESP. ram_din holds its last value when ram_rx_valid is 0.
- Simultaneous requests: strict rotation, so no requester waits more than NUM_REQ transactions. A requester dropping req_valid before acceptance is legal; it is simply not granted.
- Address wrap: addresses are used as given, with no increment. Address 0xFF is legal.

Optional Feature:
RAM_ADDR_CACHE_EN
- Defined:
  - Keep shadow registers last_wr_addr/last_rd_addr, each with a valid flag; flags are cleared on reset.
  - If the latched address matches the valid shadow of the same type, skip ADDR and go IDLE -> DATA. This saves one cycle: write latency 2, read latency 3.
  - Shadows update whenever an ADDR command is issued.
- Undefined: ADDR is always issued and the latencies are as above.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - the state enum {IDLE, ADDR, DATA, WAIT_RD, RESP};
  - DATA_W=8.
- One sub-module, rr_arbiter: parameter NUM_REQ; inputs req, advance, and last grant index; output one-hot grant; it owns the rotating pointer.
- Sequencer FSM and datapath live in the top module.

Test Plan:
1. Req0 write addr 0x10 data 0xA5 -> cycles 1,2: ram_rx_valid=1 with ram_din 0x010 then 0x1A5; cycle 3: rsp_valid=2'b01 for one cycle; busy high cycles 1-3.
2. Req1 read addr 0x10 after test 1 -> ram_din 0x210 then 0x300; cycle 4: rsp_valid=2'b10 and rsp_rdata=0xA5.
3. Both req_valid held after reset, four reads -> accept order 0,1,0,1; no back-to-back grant to the same requester while the other is waiting.
4. rst_n low during WAIT_RD -> all outputs 0 immediately, no rsp_valid. The next request from requester 1 (only requester valid) is granted with pointer restarted at 0.
5. Write 0x3C to addr 0xFF, then read 0xFF -> rsp_rdata=0x3C, with no address wrap or truncation.
6. RAM_ADDR_CACHE_EN defined, two reads of addr 0x20 -> second read issues only 0x300 and rsp_valid arrives at cycle 3. Without the macro, both reads issue 0x220 and each takes latency 4.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the command-RAM access path: opcodes, sequencer states
// and the fixed RAM data width.
package ram_ctrl_pkg;

   localparam int DATA_W = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      DATA    = 3'd2,
      WAIT_RD = 3'd3,
      RESP    = 3'd4
   } state_t;

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer
// that moves to one past the last served requester when advance is pulsed.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [NUM_REQ-1:0] grant
);

   logic [IDX_W-1:0] ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      end
   end

   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port command RAM among NUM_REQ requesters, expanding each
// transaction into address/data commands. Optional macro: RAM_ADDR_CACHE_EN.
module ram_access_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_SIZE = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic [9:0]                    ram_din,
   output logic                          ram_rx_valid,
   input  logic [DATA_W-1:0]             ram_dout,
   input  logic                          ram_tx_valid,
   output logic                          busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                state, nxt;
   logic [NUM_REQ-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx, owner;
   logic                  accept, advance, hit;
   logic                  sel_we, we_r;
   logic [ADDR_SIZE-1:0]  sel_addr;
   logic [DATA_W-1:0]     sel_wdata, wdata_r;

   function automatic logic [9:0] addr_cmd(input logic we, input logic [ADDR_SIZE-1:0] a);
      return {we ? OP_WR_ADDR : OP_RD_ADDR, DATA_W'(a)};
   endfunction

   function automatic logic [9:0] data_cmd(input logic we, input logic [DATA_W-1:0] d);
      return we ? {OP_WR_DATA, d} : {OP_RD_DATA, 8'h00};
   endfunction

   assign advance = (state == RESP);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .advance  (advance),
      .last_idx (owner),
      .grant    (gnt)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gnt_idx = IDX_W'(i);
      end
   end

   assign accept    = (state == IDLE) && (|req_valid);
   assign sel_we    = req_we[gnt_idx];
   assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
   assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

`ifdef RAM_ADDR_CACHE_EN
   // Shadows mirror the RAM's own write/read address registers, so a repeated
   // address of the same type can go straight to the data command.
   logic [ADDR_SIZE-1:0] addr_r, wr_shadow, rd_shadow;
   logic                 wr_shadow_vld, rd_shadow_vld;

   always_comb begin
      hit = sel_we ? (wr_shadow_vld && (wr_shadow == sel_addr))
                   : (rd_shadow_vld && (rd_shadow == sel_addr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r        <= '0;
         wr_shadow     <= '0;
         rd_shadow     <= '0;
         wr_shadow_vld <= 1'b0;
         rd_shadow_vld <= 1'b0;
      end else begin
         if (accept) addr_r <= sel_addr;
         if (state == ADDR) begin
            if (we_r) begin
               wr_shadow     <= addr_r;
               wr_shadow_vld <= 1'b1;
            end else begin
               rd_shadow     <= addr_r;
               rd_shadow_vld <= 1'b1;
            end
         end
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = hit ? DATA : ADDR;
         ADDR:    nxt = DATA;
         DATA:    nxt = we_r ? RESP : WAIT_RD;
         WAIT_RD: if (ram_tx_valid) nxt = RESP;
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state == IDLE) req_ready = gnt;
      if (state == RESP) rsp_valid[owner] = 1'b1;
      ram_rx_valid = (state == ADDR) || (state == DATA);
      busy         = (state != IDLE);
   end

   // ram_din is loaded one cycle ahead so it is stable for the whole command
   // cycle and holds its value while the strobe is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= '0;
         we_r      <= 1'b0;
         wdata_r   <= '0;
         ram_din   <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            owner   <= gnt_idx;
            we_r    <= sel_we;
            wdata_r <= sel_wdata;
            ram_din <= hit ? data_cmd(sel_we, sel_wdata) : addr_cmd(sel_we, sel_addr);
         end
         if (state == ADDR) ram_din <= data_cmd(we_r, wdata_r);
         if ((state == WAIT_RD) && ram_tx_valid) rsp_rdata <= ram_dout;
      end
   end

endmodule
